// File: rtl/river_lane_scheduler_pkg.sv
// Shared types and widths for the river lane scheduler slice.
package river_pkg;

  localparam int unsigned PERIOD_W = 6;
  localparam int unsigned LEVEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FREEZE  = 2'd2,
    ADVANCE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/river_lane_scheduler_if.sv
// Game-side bus of the river lane scheduler: round control in, lane/frog status out.
interface river_lane_scheduler_if import river_pkg::*; #(
  parameter int unsigned N_LANES = 4
) ();

  logic               Start;
  logic               win;
  logic               lose;
  logic               In_River;
  logic [N_LANES-1:0] Lane_Collision;
  logic [N_LANES-1:0] Lane_Tick;
  logic [N_LANES-1:0] Lane_Dir;
  logic [LEVEL_W-1:0] Level;
  logic               Frog_Carry_Valid;
  logic               Frog_Carry_Dir;
  logic               Frog_Drown;
  logic [1:0]         Sched_State;

  // Game logic side: drives round events and frog position, consumes schedule.
  modport master (
    output Start, win, lose, In_River, Lane_Collision,
    input  Lane_Tick, Lane_Dir, Level, Frog_Carry_Valid, Frog_Carry_Dir,
           Frog_Drown, Sched_State
  );

  // Scheduler side.
  modport slave (
    input  Start, win, lose, In_River, Lane_Collision,
    output Lane_Tick, Lane_Dir, Level, Frog_Carry_Valid, Frog_Carry_Dir,
           Frog_Drown, Sched_State
  );

endinterface

// File: rtl/river_lane_scheduler_lane_period_counter.sv
// Per-lane frame counter: fires a one-frame tick every period+1 enabled frames.
module lane_period_counter import river_pkg::*; (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                enable,
  input  logic                clear,
  output logic                tick_c
);

  logic [PERIOD_W-1:0] count_q;

  assign tick_c = enable && (count_q == period);

  // Count enabled frames, wrap to zero on the tick frame; hold when disabled.
  always_ff @(posedge frame_clk) begin
    if (Reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick_c ? '0 : count_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/river_lane_scheduler.sv
// Central river sequencer: lane tick scheduling, level progression, frog carry and drown.
module river_lane_scheduler import river_pkg::*; #(
  parameter int unsigned N_LANES      = 4,
  parameter int unsigned BASE_PERIOD  = 20,
  parameter int unsigned LANE_STAGGER = 4,
  parameter int unsigned LEVEL_DEC    = 3,
  parameter int unsigned MIN_PERIOD   = 2,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned DROWN_GRACE  = 3,
  parameter int unsigned DIR_INVERT   = 0
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  river_lane_scheduler_if.slave   bus
);

  localparam int unsigned DRN_W = $clog2(DROWN_GRACE + 1);

  // Lane period in 8-bit signed arithmetic, floored at MIN_PERIOD.
  function automatic logic [PERIOD_W-1:0] calc_period(input logic [LEVEL_W-1:0] lvl,
                                                      input int unsigned       lane);
    logic signed [7:0] raw;
    raw = signed'(8'(BASE_PERIOD + lane * LANE_STAGGER)) - signed'(8'(32'(lvl) * LEVEL_DEC));
    if (raw < signed'(8'(MIN_PERIOD))) begin
      return PERIOD_W'(MIN_PERIOD);
    end
    return PERIOD_W'(raw);
  endfunction

  sched_state_t       state_q, state_d;
  logic               won_q, won_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
  logic               drown_q, drown_d;

  logic [N_LANES-1:0] tick_c;
  logic [N_LANES-1:0] dir_c;
  logic               lane_en_c;
  logic               lane_clr_c;
  logic               unsupported_c;
  logic               carry_valid_c;
  logic               carry_dir_c;

  // Lanes step only in RUN, and a win/lose/reset frame is already frozen.
  assign lane_en_c     = (state_q == RUN) && !bus.win && !bus.lose && !Reset;
  assign lane_clr_c    = (state_q == IDLE) || (state_q == ADVANCE);
  assign unsupported_c = bus.In_River && !(|bus.Lane_Collision);

  for (genvar g = 0; g < int'(N_LANES); g++) begin : g_lane
    logic [PERIOD_W-1:0] period_q;

    // Period reloads only on reset and on level advance.
    always_ff @(posedge frame_clk) begin
      if (Reset) begin
        period_q <= calc_period('0, g);
      end else if (state_q == ADVANCE) begin
        period_q <= calc_period(level_d, g);
      end
    end

    lane_period_counter u_counter (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .period    (period_q),
      .enable    (lane_en_c),
      .clear     (lane_clr_c),
      .tick_c    (tick_c[g])
    );
  end

  // Fixed alternating lane directions and lowest-lane carry select.
  always_comb begin
    dir_c         = '0;
    carry_valid_c = 1'b0;
    carry_dir_c   = 1'b0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      dir_c[i] = 1'(i) ^ 1'(DIR_INVERT);
    end
    for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
      if (tick_c[i] && bus.Lane_Collision[i]) begin
        carry_valid_c = 1'b1;
        carry_dir_c   = dir_c[i];
      end
    end
  end

  // Round sequencing, level advance and drown tracking.
  always_comb begin
    state_d   = state_q;
    won_d     = won_q;
    level_d   = level_q;
    drn_cnt_d = drn_cnt_q;
    drown_d   = drown_q;

    case (state_q)
      IDLE: begin
        won_d = 1'b0;
        if (bus.Start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (unsupported_c) begin
          if (drn_cnt_q != DRN_W'(DROWN_GRACE)) begin
            drn_cnt_d = drn_cnt_q + DRN_W'(1);
          end
          if (drn_cnt_d == DRN_W'(DROWN_GRACE)) begin
            drown_d = 1'b1;
          end
        end else begin
          drn_cnt_d = '0;
        end
        if (bus.win || bus.lose) begin
          state_d = FREEZE;
          won_d   = bus.win;
        end
      end
      FREEZE: begin
        won_d = won_q || bus.win;
        if (!bus.win && !bus.lose) begin
          state_d = won_q ? ADVANCE : IDLE;
        end
      end
      ADVANCE: begin
        if (level_q < LEVEL_W'(MAX_LEVEL)) begin
          level_d = level_q + LEVEL_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Round end: drown flag and its run-length counter start fresh.
    if (state_d == IDLE) begin
      drown_d   = 1'b0;
      drn_cnt_d = '0;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      won_q     <= 1'b0;
      level_q   <= '0;
      drn_cnt_q <= '0;
      drown_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      won_q     <= won_d;
      level_q   <= level_d;
      drn_cnt_q <= drn_cnt_d;
      drown_q   <= drown_d;
    end
  end

  assign bus.Lane_Tick        = tick_c;
  assign bus.Lane_Dir         = dir_c;
  assign bus.Level            = level_q;
  assign bus.Frog_Carry_Valid = carry_valid_c;
  assign bus.Frog_Carry_Dir   = carry_dir_c;
  assign bus.Frog_Drown       = drown_q;
  assign bus.Sched_State      = state_q;

endmodule

// File: tb/tb_river_lane_scheduler.sv
// Bench for river_lane_scheduler: vector table, directed round sequences, random vs model.
module tb_river_lane_scheduler;
  import river_pkg::*;

  localparam int unsigned NL = 4;
  localparam int BASE = 20;
  localparam int STAG = 4;
  localparam int DEC  = 3;
  localparam int MINP = 2;
  localparam int MAXL = 7;
  localparam int GRACE = 3;

  logic frame_clk = 1'b0;
  logic Reset;

  always #5 frame_clk = ~frame_clk;

  river_lane_scheduler_if #(.N_LANES(NL)) bus ();

  river_lane_scheduler #(.N_LANES(NL)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int first_tk [NL];

  typedef struct packed {
    logic       st;
    logic       w;
    logic       l;
    logic       r;
    logic [3:0] c;
    logic [3:0] e_tick;
    logic       e_cv;
    logic       e_cd;
    logic       e_drown;
    logic [1:0] e_state;
    logic [2:0] e_level;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic w, input logic l, input logic r,
                       input logic [3:0] c);
    bus.Start          = st;
    bus.win            = w;
    bus.lose           = l;
    bus.In_River       = r;
    bus.Lane_Collision = c;
  endtask

  task automatic tick_clk();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 4'h0);
    tick_clk();
    tick_clk();
    Reset = 1'b0;
  endtask

  task automatic start_round();
    drive(1, 0, 0, 0, 4'h0);
    #1;
    tick_clk();
  endtask

  // Win pulse from RUN, then wait (bounded) for the scheduler to come back to IDLE.
  task automatic do_win();
    drive(0, 1, 0, 0, 4'h0);
    #1;
    tick_clk();
    drive(0, 0, 0, 0, 4'h0);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (bus.Sched_State == 2'd0) break;
      tick_clk();
    end
    check("win_returns_idle", int'(bus.Sched_State), 0);
  endtask

  // Start a round and record the first tick frame of every lane.
  task automatic run_first_tick(input int limit);
    for (int i = 0; i < int'(NL); i++) first_tk[i] = -1;
    start_round();
    for (int k = 0; k < limit; k++) begin
      drive(0, 0, 0, 0, 4'h0);
      #1;
      for (int i = 0; i < int'(NL); i++)
        if (bus.Lane_Tick[i] && first_tk[i] < 0) first_tk[i] = k;
      tick_clk();
    end
  endtask

  // Reference model state (rules-level, not the RTL encoding).
  int m_state, m_level, m_rf, m_unsup;
  bit m_drown, m_won;

  function automatic int per(input int lvl, input int lane);
    int p;
    p = BASE + lane * STAG - lvl * DEC;
    return (p < MINP) ? MINP : p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int q0[$];
    int q3[$];
    int ncarry, bad, found;

    // ---------- reset state and lane timing with carry ----------
    do_reset();
    drive(0, 0, 0, 0, 4'h0);
    #1;
    check("reset_state", int'(bus.Sched_State), 0);
    check("reset_level", int'(bus.Level), 0);
    check("reset_tick", int'(bus.Lane_Tick), 0);
    check("reset_carry", int'(bus.Frog_Carry_Valid), 0);
    check("reset_drown", int'(bus.Frog_Drown), 0);
    check("lane_dir", int'(bus.Lane_Dir), 4'b1010);

    start_round();
    ncarry = 0;
    bad = 0;
    for (int f = 0; f < 60; f++) begin
      drive(0, 0, 0, 1, 4'b0010);
      #1;
      if (bus.Lane_Tick[0]) q0.push_back(f);
      if (bus.Lane_Tick[3]) q3.push_back(f);
      if (bus.Frog_Carry_Valid) begin
        ncarry++;
        if (!bus.Lane_Tick[1] || !bus.Frog_Carry_Dir) bad++;
      end
      if (bus.Frog_Drown) bad++;
      tick_clk();
    end
    check("lane0_tick_count", q0.size(), 2);
    check("lane0_tick1", (q0.size() > 0) ? q0[0] : -1, 20);
    check("lane0_tick2", (q0.size() > 1) ? q0[1] : -1, 41);
    check("lane3_tick_count", q3.size(), 1);
    check("lane3_tick1", (q3.size() > 0) ? q3[0] : -1, 32);
    check("carry_count", ncarry, 2);
    check("carry_bad_events", bad, 0);

    // ---------- vector table: drown then lose ----------
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
    do_reset();
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].st, tbl[v].w, tbl[v].l, tbl[v].r, tbl[v].c);
      #1;
      check($sformatf("vec%0d_tick", v), int'(bus.Lane_Tick), int'(tbl[v].e_tick));
      check($sformatf("vec%0d_carry", v), int'(bus.Frog_Carry_Valid), int'(tbl[v].e_cv));
      check($sformatf("vec%0d_drown", v), int'(bus.Frog_Drown), int'(tbl[v].e_drown));
      check($sformatf("vec%0d_state", v), int'(bus.Sched_State), int'(tbl[v].e_state));
      check($sformatf("vec%0d_level", v), int'(bus.Level), int'(tbl[v].e_level));
      tick_clk();
    end

    // ---------- win freezes the tick frame, advances level ----------
    do_reset();
    start_round();
    for (int f = 0; f < 20; f++) begin
      drive(0, 0, 0, 0, 4'h0);
      #1;
      tick_clk();
    end
    drive(0, 1, 0, 0, 4'h0);
    #1;
    check("win_kills_tick", int'(bus.Lane_Tick), 0);
    tick_clk();
    drive(0, 1, 0, 0, 4'h0);
    #1;
    check("freeze_state", int'(bus.Sched_State), 2);
    check("freeze_tick", int'(bus.Lane_Tick), 0);
    tick_clk();
    drive(0, 0, 0, 0, 4'h0);
    #1;
    check("freeze_until_drop", int'(bus.Sched_State), 2);
    tick_clk();
    check("advance_state", int'(bus.Sched_State), 3);
    check("advance_level_old", int'(bus.Level), 0);
    tick_clk();
    check("post_advance_idle", int'(bus.Sched_State), 0);
    check("level_after_win", int'(bus.Level), 1);
    run_first_tick(20);
    check("l1_lane0_first", first_tk[0], 17);
    do_win();
    for (int k = 0; k < 5; k++) begin
      start_round();
      do_win();
    end
    check("level_saturated", int'(bus.Level), 7);
    run_first_tick(15);
    check("l7_lane0_first", first_tk[0], 2);
    check("l7_lane3_first", first_tk[3], 11);
    do_win();
    check("level_eighth_win", int'(bus.Level), 7);

    // ---------- reset during a lane2 tick at level 4 ----------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start_round();
      do_win();
    end
    check("level_four", int'(bus.Level), 4);
    start_round();
    found = -1;
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 0, 0, 4'h0);
      #1;
      if (bus.Lane_Tick[2]) begin
        found = k;
        Reset = 1'b1;
        tick_clk();
        break;
      end
      tick_clk();
    end
    check("l4_lane2_tick_frame", found, 16);
    Reset = 1'b0;
    drive(0, 0, 0, 0, 4'h0);
    #1;
    check("rst_mid_state", int'(bus.Sched_State), 0);
    check("rst_mid_level", int'(bus.Level), 0);
    check("rst_mid_tick", int'(bus.Lane_Tick), 0);
    check("rst_mid_carry", int'(bus.Frog_Carry_Valid), 0);
    check("rst_mid_drown", int'(bus.Frog_Drown), 0);

    // ---------- random stimulus against the reference model ----------
    do_reset();
    m_state = 0; m_level = 0; m_rf = 0; m_unsup = 0; m_drown = 0; m_won = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic rst, st, w, l, r;
      logic [3:0] c, e_tick;
      logic e_cv, e_cd;
      rst = ($urandom_range(0, 499) == 0);
      st  = ($urandom_range(0, 3) == 0);
      w   = ($urandom_range(0, 39) == 0);
      l   = ($urandom_range(0, 39) == 0);
      r   = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      Reset = rst;
      drive(st, w, l, r, c);
      #1;
      e_tick = '0;
      if (m_state == 1 && !w && !l && !rst)
        for (int i = 0; i < int'(NL); i++)
          if (m_rf % (per(m_level, i) + 1) == per(m_level, i)) e_tick[i] = 1'b1;
      e_cv = 1'b0;
      e_cd = 1'b0;
      for (int i = 0; i < int'(NL); i++)
        if (e_tick[i] && c[i] && !e_cv) begin
          e_cv = 1'b1;
          e_cd = 1'(i % 2);
        end
      check("rnd_tick", int'(bus.Lane_Tick), int'(e_tick));
      check("rnd_carry_valid", int'(bus.Frog_Carry_Valid), int'(e_cv));
      check("rnd_carry_dir", int'(bus.Frog_Carry_Dir), int'(e_cd));
      check("rnd_drown", int'(bus.Frog_Drown), int'(m_drown));
      check("rnd_state", int'(bus.Sched_State), m_state);
      check("rnd_level", int'(bus.Level), m_level);
      if (rst) begin
        m_state = 0; m_level = 0; m_rf = 0; m_unsup = 0; m_drown = 0; m_won = 0;
      end else begin
        case (m_state)
          0: if (st) begin m_state = 1; m_rf = 0; m_unsup = 0; end
          1: begin
            if (r && c == 4'h0) begin
              m_unsup = (m_unsup + 1 > GRACE) ? GRACE : m_unsup + 1;
              if (m_unsup >= GRACE) m_drown = 1;
            end else begin
              m_unsup = 0;
            end
            if (w || l) begin m_state = 2; m_won = w; end
            else m_rf++;
          end
          2: begin
            if (!w && !l) begin
              if (m_won) m_state = 3;
              else begin m_state = 0; m_drown = 0; end
            end
            if (w) m_won = 1;
          end
          default: begin
            m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
            m_drown = 0;
            m_state = 0;
          end
        endcase
      end
      tick_clk();
    end
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/river_lane_scheduler.md
Name: river_lane_scheduler

Overview:
- Central sequencer for the river section.
- Generates per-lane one-frame move ticks with level-dependent periods, and fixed per-lane directions.
- Freezes all lanes on win or lose, and advances the difficulty level after a win.
- Resolves which lane carries the frog and flags drowning. Lane movers step only on their tick; the frog mover consumes the carry and drown outputs.

Parameters:
- N_LANES, 4, number of river lanes scheduled.
- BASE_PERIOD, 20, frames between steps for lane 0 at level 0.
- LANE_STAGGER, 4, extra frames per lane index.
- LEVEL_DEC, 3, frames removed per level.
- MIN_PERIOD, 2, floor on any lane period.
- MAX_LEVEL, 7, saturating level ceiling.
- DROWN_GRACE, 3, consecutive unsupported frames before drowning.
- DIR_INVERT, 0, XORed into every lane direction.

Ports:
- frame_clk  in  1  frame clock; sole clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  leave IDLE and begin a round.
- win  in  1  round won (level).
- lose  in  1  round lost (level).
- In_River  in  1  frog currently on a river row.
- Lane_Collision  in  N_LANES  per-lane frog-on-pad flags.
- Lane_Tick  out  N_LANES  one-frame step enables.
- Lane_Dir  out  N_LANES  1 = right, 0 = left.
- Level  out  3  current difficulty level.
- Frog_Carry_Valid  out  1  frog must step with a pad this frame.
- Frog_Carry_Dir  out  1  direction of that step.
- Frog_Drown  out  1  sticky drown flag, held until round end.
- Sched_State  out  2  IDLE=0, RUN=1, FREEZE=2, ADVANCE=3.

Behaviour:
- Clocking and reset:
  - One clock (frame_clk); Reset is synchronous and active-high. All state updates on the rising edge of frame_clk.
  - Reset values: state IDLE, Level 0, all lane counters 0, Lane_Tick 0, Frog_Carry_Valid 0, Frog_Carry_Dir 0, Frog_Drown 0, drown counter 0.
  - Reset asserted in any state, including mid-tick, overrides every other input that cycle.
- Lane direction:
  - Lane_Dir[i] = i[0] ^ DIR_INVERT. Combinational and constant.
- Lane period:
  - period[i] = BASE_PERIOD + i*LANE_STAGGER - Level*LEVEL_DEC.
  - Compute in 8-bit signed; clamp to MIN_PERIOD when the result is below MIN_PERIOD.
  - Stored as 6 bits. Recomputed only in ADVANCE and on Reset.
- IDLE:
  - Ticks 0, counters held at 0.
  - Start=1 -> RUN next cycle.
- RUN:
  - Each lane counter increments every frame.
  - When count[i]==period[i]: Lane_Tick[i]=1 for that cycle and count[i] returns to 0.
  - First tick of lane i arrives period[i] cycles after entering RUN, i.e. every period+1 frames.
  - win or lose -> FREEZE. In the same cycle all ticks are forced 0 and counters hold; win has priority over lose.
- FREEZE:
  - Ticks, carry and counters all held at 0/frozen.
  - win still high -> ADVANCE when both win and lose drop.
  - lose -> IDLE when both drop; Level unchanged.
- ADVANCE (one cycle):
  - Level = min(Level+1, MAX_LEVEL); reload periods; clear counters and Frog_Drown.
  - Next state IDLE.
- Carry (RUN only):
  - Frog_Carry_Valid=1 in a cycle where some lane i has Lane_Tick[i] & Lane_Collision[i].
  - Lowest such i wins; Frog_Carry_Dir=Lane_Dir[i]. Same-cycle (combinational from tick).
- Drown (RUN only):
  - Drown counter increments when In_River & ~|Lane_Collision, and clears otherwise.
  - Reaching DROWN_GRACE sets Frog_Drown (sticky). Counter saturates.
  - Frog_Drown clears in IDLE entry and in ADVANCE.

Decomposition:
- Package river_pkg: sched_state_t enum (IDLE, RUN, FREEZE, ADVANCE) and the PERIOD_W=6 and LEVEL_W=3 constants.
- One sub-module, lane_period_counter (period in, enable, clear, tick out), instanced N_LANES times by generate.

Test Plan:
- Reset, Start, run 60 frames -> lane0 ticks at frames 20, 41; lane3 (period 32) ticks at frame 32 only; Lane_Dir=4'b1010.
- Lane_Collision=4'b0010 held, In_River=1 -> Frog_Carry_Valid on each lane1 tick (period 24) with Dir=1; Frog_Drown stays 0.
- win pulse at frame 10 -> ticks stop immediately; ADVANCE -> Level=1, lane0 period 17; after Start, first lane0 tick at 17 frames.
- Seven wins -> Level saturates at 7; lane0 period clamps to 2; lane3 period 11; an eighth win keeps Level=7.
- In_River=1, Lane_Collision=0 for 3 frames -> Frog_Drown=1 and stays set; lose -> FREEZE -> IDLE, Level unchanged, Frog_Drown cleared.
- Reset asserted during a lane2 tick cycle at Level 4 -> next cycle IDLE, Level=0, all outputs 0.
